cpu_run_monitor: RTL and testbench

- Synthesizable run controller/monitor placed beside the CPU core. Watches the fetched instruction word and PC every cycle.
- Counts cycles and retired instructions.
- Ends the run on any of three events: a configurable halt sentinel, a PC stall (hung loop) or counter saturation. It then freezes its statistics for readout on display logic or by a bench.

---
 rtl/cpu_run_monitor.sv | 197 +++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller placed beside the CPU core.
// Counts cycles and retired instructions while running and ends the run on a
// halt sentinel, a stuck PC or cycle-counter saturation, then freezes its
// statistics until clear or reset.
module cpu_run_monitor #(
   parameter int unsigned XLEN        = 32,
   parameter logic [31:0] HALT_WORD   = 32'h7FFF_FFFF,
   parameter int unsigned HALT_REPEAT = 1,
   parameter int unsigned STALL_LIMIT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clear_i,
   input  logic [XLEN-1:0]  instr_i,
   input  logic [XLEN-1:0]  pc_i,
   output logic             halt_o,
   output logic [1:0]       halt_cause_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] cycle_count_o,
   output logic [CNT_W-1:0] instr_count_o,
   output logic [XLEN-1:0]  last_pc_o
);

   // Sentinel counter holds 0..HALT_REPEAT, stall counter 0..STALL_LIMIT-1.
   localparam int unsigned SENT_W  = $clog2(HALT_REPEAT + 1);
   localparam int unsigned STALL_W = $clog2(STALL_LIMIT);

   localparam logic [XLEN-1:0]    HALT_W     = XLEN'(HALT_WORD);
   localparam logic [SENT_W-1:0]  SENT_LAST  = SENT_W'(HALT_REPEAT - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_SENT  = 2'd1,
      CAUSE_STALL = 2'd2,
      CAUSE_OVF   = 2'd3
   } cause_t;

   state_t             state_q, state_d;
   cause_t             cause_q, cause_d;
   logic               halt_q, halt_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d;
   logic [CNT_W-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]    last_pc_q, last_pc_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic               pc_vld_q, pc_vld_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [SENT_W-1:0]  sent_q, sent_d;

   logic is_halt_word;
   logic same_pc;
   logic sent_hit;
   logic stall_hit;
   logic ovf_hit;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Halt conditions use the pre-increment register values.
   assign is_halt_word = (instr_i == HALT_W);
   assign same_pc      = pc_vld_q && (pc_i == pc_q);
   assign sent_hit     = is_halt_word && (sent_q == SENT_LAST);
   assign stall_hit    = same_pc && (stall_q == STALL_LAST);
   assign ovf_hit      = (cycle_q == {CNT_W{1'b1}});

   // Next-state, counter and halt bookkeeping; clear overrides everything.
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      halt_d    = halt_q;
      cycle_d   = cycle_q;
      instr_d   = instr_q;
      last_pc_d = last_pc_q;
      pc_d      = pc_q;
      pc_vld_d  = pc_vld_q;
      stall_d   = stall_q;
      sent_d    = sent_q;

      case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            cycle_d  = sat_inc(cycle_q);
            pc_d     = pc_i;
            pc_vld_d = 1'b1;
            if (pc_vld_q && !same_pc) begin
               instr_d = sat_inc(instr_q);
               stall_d = '0;
            end else if (same_pc) begin
               stall_d = stall_q + STALL_W'(1);
            end else begin
               stall_d = stall_q;
            end
            if (is_halt_word) begin
               sent_d = sent_q + SENT_W'(1);
            end else begin
               sent_d = '0;
            end
            if (sent_hit || stall_hit || ovf_hit) begin
               state_d   = ST_HALTED;
               halt_d    = 1'b1;
               last_pc_d = pc_i;
               if (sent_hit) begin
                  cause_d = CAUSE_SENT;
               end else if (stall_hit) begin
                  cause_d = CAUSE_STALL;
               end else begin
                  cause_d = CAUSE_OVF;
               end
            end else if (!en_i) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (en_i) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear_i) begin
         state_d   = ST_IDLE;
         cause_d   = CAUSE_NONE;
         halt_d    = 1'b0;
         cycle_d   = '0;
         instr_d   = '0;
         last_pc_d = '0;
         pc_d      = '0;
         pc_vld_d  = 1'b0;
         stall_d   = '0;
         sent_d    = '0;
      end else begin
         pc_vld_d  = pc_vld_d;
      end
   end

   // State and statistics registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cause_q   <= CAUSE_NONE;
         halt_q    <= 1'b0;
         cycle_q   <= '0;
         instr_q   <= '0;
         last_pc_q <= '0;
         pc_q      <= '0;
         pc_vld_q  <= 1'b0;
         stall_q   <= '0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         halt_q    <= halt_d;
         cycle_q   <= cycle_d;
         instr_q   <= instr_d;
         last_pc_q <= last_pc_d;
         pc_q      <= pc_d;
         pc_vld_q  <= pc_vld_d;
         stall_q   <= stall_d;
         sent_q    <= sent_d;
      end
   end

   assign halt_o        = halt_q;
   assign halt_cause_o  = cause_q;
   assign state_o       = state_q;
   assign cycle_count_o = cycle_q;
   assign instr_count_o = instr_q;
   assign last_pc_o     = last_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: stimulus pushes the expected
// post-edge outputs from a history-based reference model, a monitor pops
// and compares one entry per clock edge.
module tb_cpu_run_monitor;

   localparam int          CW   = 6;
   localparam int          HR   = 3;
   localparam int          SL   = 4;
   localparam logic [31:0] HW   = 32'h7FFF_FFFF;
   localparam int          MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          clear = 1'b0;
   logic [31:0]   instr = 32'd0;
   logic [31:0]   pc = 32'd0;
   logic          halt;
   logic [1:0]    halt_cause;
   logic [1:0]    state;
   logic [CW-1:0] cycle_count;
   logic [CW-1:0] instr_count;
   logic [31:0]   last_pc;

   cpu_run_monitor #(
      .XLEN(32), .HALT_WORD(HW), .HALT_REPEAT(HR), .STALL_LIMIT(SL), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .en_i(en), .clear_i(clear), .instr_i(instr), .pc_i(pc),
      .halt_o(halt), .halt_cause_o(halt_cause), .state_o(state),
      .cycle_count_o(cycle_count), .instr_count_o(instr_count), .last_pc_o(last_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          h;
      logic [1:0]    cause;
      logic [1:0]    st;
      logic [CW-1:0] cc;
      logic [CW-1:0] ic;
      logic [31:0]   lp;
   } obs_t;

   obs_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: run statistics derived from the recorded RUN history.
   int          m_st;
   int          m_cyc;
   int          m_ins;
   int          m_cause;
   logic [31:0] m_last;
   logic [31:0] pch[$];
   logic [31:0] insh[$];

   function automatic void mreset();
      m_st = 0; m_cyc = 0; m_ins = 0; m_cause = 0; m_last = 32'd0;
      pch.delete(); insh.delete();
   endfunction

   function automatic int trail_pc();
      int n = 0;
      for (int i = pch.size() - 1; i >= 0; i--) begin
         if (pch[i] == pch[pch.size() - 1]) n++;
         else break;
      end
      return n;
   endfunction

   function automatic int trail_sent();
      int n = 0;
      for (int i = insh.size() - 1; i >= 0; i--) begin
         if (insh[i] == HW) n++;
         else break;
      end
      return n;
   endfunction

   function automatic void step(input logic e, input logic c, input logic [31:0] ins, input logic [31:0] p);
      bit ov;
      if (c) begin
         mreset();
         return;
      end
      if (m_st == 0 || m_st == 2) begin
         if (e) m_st = 1;
      end else if (m_st == 1) begin
         ov = (m_cyc == MAXC);
         if (pch.size() > 0 && pch[pch.size() - 1] != p) m_ins = (m_ins < MAXC) ? m_ins + 1 : MAXC;
         pch.push_back(p);
         insh.push_back(ins);
         m_cyc = (m_cyc < MAXC) ? m_cyc + 1 : MAXC;
         if (trail_sent() >= HR) m_cause = 1;
         else if (trail_pc() >= SL) m_cause = 2;
         else if (ov) m_cause = 3;
         if (m_cause != 0) begin
            m_st = 3;
            m_last = p;
         end else if (!e) begin
            m_st = 2;
         end
      end
   endfunction

   function automatic obs_t m_obs();
      obs_t o;
      o.h = (m_st == 3); o.cause = 2'(m_cause); o.st = 2'(m_st);
      o.cc = CW'(m_cyc); o.ic = CW'(m_ins); o.lp = m_last;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.h = halt; o.cause = halt_cause; o.st = state;
      o.cc = cycle_count; o.ic = instr_count; o.lp = last_pc;
      return o;
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got h=%0d cause=%0d st=%0d cyc=%0d ins=%0d lpc=%h want h=%0d cause=%0d st=%0d cyc=%0d ins=%0d lpc=%h",
                  name, $time, got.h, got.cause, got.st, got.cc, got.ic, got.lp,
                  want.h, want.cause, want.st, want.cc, want.ic, want.lp);
      end
   endtask

   // Monitor: one expectation per edge, checked just after the edge.
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("edge", dut_obs(), e);
         end
      end
   end

   function automatic logic [31:0] nop();
      logic [31:0] r;
      r = $urandom;
      if (r == HW) r = 32'd0;
      return r;
   endfunction

   task automatic drive(input logic e, input logic c, input logic [31:0] ins, input logic [31:0] p);
      @(negedge clk);
      en = e; clear = c; instr = ins; pc = p;
      step(e, c, ins, p);
      expq.push_back(m_obs());
   endtask

   // Fixed expectations taken straight from the scenario arithmetic.
   task automatic spot(input string name, input int st, input int cause, input int cc, input int ic, input logic [31:0] lp);
      obs_t w;
      #7;
      w.h = (st == 3); w.cause = 2'(cause); w.st = 2'(st);
      w.cc = CW'(cc); w.ic = CW'(ic); w.lp = lp;
      check(name, dut_obs(), w);
   endtask

   task automatic run_sentinel(input string tag);
      logic [31:0] pat [7];
      pat = '{32'd0, HW, HW, 32'd0, HW, HW, HW};
      drive(1'b1, 1'b0, nop(), 32'd0);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, (pat[i] == HW) ? HW : nop(), 32'(4 * i));
      spot({tag, "_halt"}, 3, 1, 7, 6, 32'd24);
   endtask

   initial begin
      mreset();
      #3;
      check("reset", dut_obs(), '0);
      @(negedge clk);
      rst = 1'b0;

      // Sentinel needing three consecutive hits, then frozen counters.
      run_sentinel("sent");
      for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'b0, HW, $urandom);
      spot("sent_frozen", 3, 1, 7, 6, 32'd24);
      drive(1'b0, 1'b1, nop(), 32'd0);
      spot("clear_idle", 0, 0, 0, 0, 32'd0);

      // Stuck PC.
      drive(1'b1, 1'b0, nop(), 32'd0);
      drive(1'b1, 1'b0, nop(), 32'd0);
      drive(1'b1, 1'b0, nop(), 32'd4);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, nop(), 32'd8);
      spot("stall", 3, 2, 6, 2, 32'd8);
      drive(1'b0, 1'b1, nop(), 32'd0);

      // Pause keeps the stall history of a constant PC.
      drive(1'b1, 1'b0, nop(), 32'd100);
      drive(1'b1, 1'b0, nop(), 32'd100);
      drive(1'b1, 1'b0, nop(), 32'd100);
      drive(1'b0, 1'b0, nop(), 32'd100);
      spot("pause_enter", 2, 0, 3, 0, 32'd0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, nop(), 32'd100);
      drive(1'b1, 1'b0, nop(), 32'd100);
      spot("pause_resume", 1, 0, 3, 0, 32'd0);
      drive(1'b1, 1'b0, nop(), 32'd100);
      spot("pause_stall", 3, 2, 4, 0, 32'd100);
      drive(1'b0, 1'b1, nop(), 32'd0);

      // Cycle counter saturation.
      drive(1'b1, 1'b0, nop(), 32'd0);
      for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, nop(), 32'(4 * i));
      spot("overflow", 3, 3, MAXC, MAXC, 32'd252);
      drive(1'b0, 1'b1, nop(), 32'd0);

      // Sentinel and overflow on the same edge: sentinel wins.
      drive(1'b1, 1'b0, nop(), 32'd0);
      for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, (i >= 61) ? HW : nop(), 32'(4 * i));
      spot("sent_ovf", 3, 1, MAXC, MAXC, 32'd252);
      drive(1'b0, 1'b1, nop(), 32'd0);

      // Asynchronous reset between edges while running.
      drive(1'b1, 1'b0, nop(), 32'd0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, nop(), 32'(4 * i));
      #7;
      rst = 1'b1; en = 1'b0; clear = 1'b0;
      #1;
      check("async_rst", dut_obs(), '0);
      #1;
      rst = 1'b0;
      mreset();

      // Re-run reproduces the sentinel scenario.
      run_sentinel("rerun");
      drive(1'b0, 1'b1, nop(), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic        e, c;
         logic [31:0] p;
         int          r;
         e = ($urandom_range(0, 9) != 0);
         c = (m_st == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 79) == 0);
         r = $urandom_range(0, 9);
         if (r < 5) p = pc + 32'd4;
         else if (r < 8) p = pc;
         else p = $urandom;
         drive(e, c, ($urandom_range(0, 3) == 0) ? HW : nop(), p);
      end

      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d want=0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
